// File: rtl/kmeans_core_param.sv
// Iterative k-means engine over an external 3-D point memory with one-cycle read latency.
// Centroids seed from the first K points; passes repeat until no label changes or MAX_ITER passes.
module kmeans_core_param #(
    parameter int N_POINTS = 41,
    parameter int K        = 7,
    parameter int W        = 8,
    parameter int MAX_ITER = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count,
    output logic [$clog2(N_POINTS+1)-1:0] changed_count,
    output logic [$clog2(N_POINTS)-1:0]   pt_addr,
    input  logic [W-1:0]                  pt_x,
    input  logic [W-1:0]                  pt_y,
    input  logic [W-1:0]                  pt_z,
    output logic                          lbl_we,
    output logic [$clog2(N_POINTS)-1:0]   lbl_addr,
    output logic [$clog2(K)-1:0]          lbl_wdata,
    input  logic [$clog2(K)-1:0]          cen_sel,
    output logic [W-1:0]                  cen_x,
    output logic [W-1:0]                  cen_y,
    output logic [W-1:0]                  cen_z
);
    localparam int AW = $clog2(N_POINTS);
    localparam int LW = $clog2(K);
    localparam int IW = $clog2(MAX_ITER+1);
    localparam int CW = $clog2(N_POINTS+1);
    localparam int DW = 2*W + 2;
    localparam int SW = W + AW;
    localparam int BW = $clog2(SW) + 1;

    // IDLE wait | INIT seed centroids | FETCH/LATCH read point | DIST scan centroids | WRITE emit label | UPDATE divide | CHECK converge | DONE hold
    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_FETCH, S_LATCH, S_DIST, S_WRITE, S_UPDATE, S_CHECK, S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [W-1:0]        r_cx [K];
    logic [W-1:0]        r_cy [K];
    logic [W-1:0]        r_cz [K];
    logic [SW-1:0]       r_sx [K];
    logic [SW-1:0]       r_sy [K];
    logic [SW-1:0]       r_sz [K];
    logic [CW-1:0]       r_cnt [K];
    logic [LW-1:0]       r_lbl [N_POINTS];
    logic [N_POINTS-1:0] r_lbl_vld;
    logic [W-1:0]        r_px, r_py, r_pz;
    logic [AW-1:0]       r_idx;
    logic [LW-1:0]       r_k, r_best;
    logic [DW-1:0]       r_best_d;
    logic                r_phase;
    logic [1:0]          r_ax;
    logic [BW-1:0]       r_bit;
    logic [CW-1:0]       r_rem;
    logic [SW-1:0]       r_quo;
    logic [IW-1:0]       r_iter;
    logic [CW-1:0]       r_changed;

    logic [W-1:0]  w_dx, w_dy, w_dz;
    logic [DW-1:0] w_ex, w_ey, w_ez, w_d;
    logic [CW:0]   w_trial;
    logic [CW-1:0] w_rem_nx;
    logic [SW-1:0] w_quo_nx, w_sum_nx;
    logic          w_k_last, w_p_last, w_bit_last, w_stop;

    assign w_dx = (r_px >= r_cx[r_k]) ? r_px - r_cx[r_k] : r_cx[r_k] - r_px;
    assign w_dy = (r_py >= r_cy[r_k]) ? r_py - r_cy[r_k] : r_cy[r_k] - r_py;
    assign w_dz = (r_pz >= r_cz[r_k]) ? r_pz - r_cz[r_k] : r_cz[r_k] - r_pz;
    assign w_ex = {{(DW-W){1'b0}}, w_dx};
    assign w_ey = {{(DW-W){1'b0}}, w_dy};
    assign w_ez = {{(DW-W){1'b0}}, w_dz};
    assign w_d  = w_ex*w_ex + w_ey*w_ey + w_ez*w_ez;

    // Remainder stays below the divisor, so modular CW-bit subtraction is exact.
    always_comb begin
        w_trial = {r_rem, r_quo[SW-1]};
        if (w_trial >= {1'b0, r_cnt[r_k]}) begin
            w_rem_nx = w_trial[CW-1:0] - r_cnt[r_k];
            w_quo_nx = {r_quo[SW-2:0], 1'b1};
        end else begin
            w_rem_nx = w_trial[CW-1:0];
            w_quo_nx = {r_quo[SW-2:0], 1'b0};
        end
    end

    always_comb begin
        case (r_ax)
            2'd3:    w_sum_nx = r_sx[r_k];
            2'd0:    w_sum_nx = r_sy[r_k];
            default: w_sum_nx = r_sz[r_k];
        endcase
    end

    assign w_k_last   = (r_k == LW'(K-1));
    assign w_p_last   = (r_idx == AW'(N_POINTS-1));
    assign w_bit_last = (r_bit == BW'(SW-1));
    assign w_stop     = (r_changed == '0) || (r_iter == IW'(MAX_ITER-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_INIT;
            S_INIT:   if (r_phase && w_k_last) w_next = S_FETCH;
            S_FETCH:  w_next = S_LATCH;
            S_LATCH:  w_next = S_DIST;
            S_DIST:   if (w_k_last) w_next = S_WRITE;
            S_WRITE:  w_next = w_p_last ? S_UPDATE : S_FETCH;
            S_UPDATE: if (r_ax == 2'd2 && w_bit_last && w_k_last) w_next = S_CHECK;
            S_CHECK:  w_next = w_stop ? S_DONE : S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                r_cx[i]  <= '0;
                r_cy[i]  <= '0;
                r_cz[i]  <= '0;
                r_sx[i]  <= '0;
                r_sy[i]  <= '0;
                r_sz[i]  <= '0;
                r_cnt[i] <= '0;
            end
            for (int i = 0; i < N_POINTS; i++) r_lbl[i] <= '0;
            r_lbl_vld <= '0;
            r_px      <= '0;
            r_py      <= '0;
            r_pz      <= '0;
            r_idx     <= '0;
            r_k       <= '0;
            r_best    <= '0;
            r_best_d  <= '0;
            r_phase   <= 1'b0;
            r_ax      <= '0;
            r_bit     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_iter    <= '0;
            r_changed <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_iter    <= '0;
                        r_changed <= '0;
                        r_idx     <= '0;
                        r_k       <= '0;
                        r_phase   <= 1'b0;
                        r_lbl_vld <= '0;
                    end
                end
                S_INIT: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_cx[r_k] <= pt_x;
                        r_cy[r_k] <= pt_y;
                        r_cz[r_k] <= pt_z;
                        if (w_k_last) begin
                            r_k   <= '0;
                            r_idx <= '0;
                        end else begin
                            r_k   <= r_k + LW'(1);
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end
                S_LATCH: begin
                    r_px <= pt_x;
                    r_py <= pt_y;
                    r_pz <= pt_z;
                    r_k  <= '0;
                end
                S_DIST: begin
                    if (r_k == '0 || w_d < r_best_d) begin
                        r_best_d <= w_d;
                        r_best   <= r_k;
                    end
                    r_k <= w_k_last ? '0 : r_k + LW'(1);
                end
                S_WRITE: begin
                    r_lbl[r_idx]     <= r_best;
                    r_lbl_vld[r_idx] <= 1'b1;
                    if (!r_lbl_vld[r_idx] || r_lbl[r_idx] != r_best)
                        r_changed <= r_changed + CW'(1);
                    r_sx[r_best]  <= r_sx[r_best] + SW'(r_px);
                    r_sy[r_best]  <= r_sy[r_best] + SW'(r_py);
                    r_sz[r_best]  <= r_sz[r_best] + SW'(r_pz);
                    r_cnt[r_best] <= r_cnt[r_best] + CW'(1);
                    if (w_p_last) begin
                        r_idx <= '0;
                        r_k   <= '0;
                        r_ax  <= 2'd3;
                        r_bit <= '0;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                S_UPDATE: begin
                    // r_ax==3 is the per-cluster load cycle; 0..2 walk x, y, z.
                    if (r_ax == 2'd3) begin
                        r_quo <= w_sum_nx;
                        r_rem <= '0;
                        r_bit <= '0;
                        r_ax  <= 2'd0;
                    end else begin
                        r_quo <= w_quo_nx;
                        r_rem <= w_rem_nx;
                        r_bit <= r_bit + BW'(1);
                        if (w_bit_last) begin
                            r_bit <= '0;
                            if (r_cnt[r_k] != '0) begin
                                case (r_ax)
                                    2'd0:    r_cx[r_k] <= w_quo_nx[W-1:0];
                                    2'd1:    r_cy[r_k] <= w_quo_nx[W-1:0];
                                    default: r_cz[r_k] <= w_quo_nx[W-1:0];
                                endcase
                            end
                            if (r_ax == 2'd2) begin
                                r_sx[r_k]  <= '0;
                                r_sy[r_k]  <= '0;
                                r_sz[r_k]  <= '0;
                                r_cnt[r_k] <= '0;
                                r_ax       <= 2'd3;
                                r_k        <= w_k_last ? '0 : r_k + LW'(1);
                            end else begin
                                r_quo <= w_sum_nx;
                                r_rem <= '0;
                                r_ax  <= r_ax + 2'd1;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    r_iter <= r_iter + IW'(1);
                    if (!w_stop) begin
                        r_changed <= '0;
                        r_idx     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done          = (r_state == S_DONE);
    assign iter_count    = r_iter;
    assign changed_count = r_changed;
    assign pt_addr       = r_idx;
    assign lbl_we        = (r_state == S_WRITE);
    assign lbl_addr      = r_idx;
    assign lbl_wdata     = r_best;

    always_comb begin
        cen_x = '0;
        cen_y = '0;
        cen_z = '0;
        if (int'(cen_sel) < K) begin
            cen_x = r_cx[cen_sel];
            cen_y = r_cy[cen_sel];
            cen_z = r_cz[cen_sel];
        end
    end
endmodule

// File: tb/tb_kmeans_core_param.sv
// Directed k-means scenarios on three engine sizes, checked against a plain integer k-means model.
module tb_kmeans_core_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic st_a, st_b, st_c;
    int   csel;
    logic [7:0] mx [64];
    logic [7:0] my [64];
    logic [7:0] mz [64];

    int n_chk = 0;
    int n_err = 0;

    // Instance A: N=4 K=2 MAX_ITER=16
    logic a_busy, a_done, a_we, a_cs;
    logic [4:0] a_iter;
    logic [2:0] a_chg;
    logic [1:0] a_pa, a_la;
    logic       a_lw;
    logic [7:0] a_px, a_py, a_pz, a_cx, a_cy, a_cz;
    // Instance B: N=4 K=2 MAX_ITER=1
    logic b_busy, b_done, b_we, b_cs;
    logic [0:0] b_iter;
    logic [2:0] b_chg;
    logic [1:0] b_pa, b_la;
    logic       b_lw;
    logic [7:0] b_px, b_py, b_pz, b_cx, b_cy, b_cz;
    // Instance C: default sizes
    logic c_busy, c_done, c_we;
    logic [4:0] c_iter;
    logic [5:0] c_chg, c_pa, c_la;
    logic [2:0] c_lw, c_cs;
    logic [7:0] c_px, c_py, c_pz, c_cx, c_cy, c_cz;

    assign a_cs = csel[0];
    assign b_cs = csel[0];
    assign c_cs = csel[2:0];

    kmeans_core_param #(.N_POINTS(4), .K(2), .W(8), .MAX_ITER(16)) u_a (
        .clk(clk), .rst(rst), .start(st_a), .busy(a_busy), .done(a_done),
        .iter_count(a_iter), .changed_count(a_chg), .pt_addr(a_pa),
        .pt_x(a_px), .pt_y(a_py), .pt_z(a_pz), .lbl_we(a_we), .lbl_addr(a_la),
        .lbl_wdata(a_lw), .cen_sel(a_cs), .cen_x(a_cx), .cen_y(a_cy), .cen_z(a_cz));

    kmeans_core_param #(.N_POINTS(4), .K(2), .W(8), .MAX_ITER(1)) u_b (
        .clk(clk), .rst(rst), .start(st_b), .busy(b_busy), .done(b_done),
        .iter_count(b_iter), .changed_count(b_chg), .pt_addr(b_pa),
        .pt_x(b_px), .pt_y(b_py), .pt_z(b_pz), .lbl_we(b_we), .lbl_addr(b_la),
        .lbl_wdata(b_lw), .cen_sel(b_cs), .cen_x(b_cx), .cen_y(b_cy), .cen_z(b_cz));

    kmeans_core_param #(.N_POINTS(41), .K(7), .W(8), .MAX_ITER(16)) u_c (
        .clk(clk), .rst(rst), .start(st_c), .busy(c_busy), .done(c_done),
        .iter_count(c_iter), .changed_count(c_chg), .pt_addr(c_pa),
        .pt_x(c_px), .pt_y(c_py), .pt_z(c_pz), .lbl_we(c_we), .lbl_addr(c_la),
        .lbl_wdata(c_lw), .cen_sel(c_cs), .cen_x(c_cx), .cen_y(c_cy), .cen_z(c_cz));

    // Synchronous point memories, one read port per instance.
    always @(posedge clk) begin
        a_px <= mx[a_pa]; a_py <= my[a_pa]; a_pz <= mz[a_pa];
        b_px <= mx[b_pa]; b_py <= my[b_pa]; b_pz <= mz[b_pa];
        c_px <= mx[c_pa]; c_py <= my[c_pa]; c_pz <= mz[c_pa];
    end

    int   sel;
    logic m_busy, m_done, m_we;
    int   m_iter, m_chg, m_pa, m_la, m_lw, m_cx, m_cy, m_cz;
    always_comb begin
        case (sel)
            1: begin
                m_busy = b_busy; m_done = b_done; m_we = b_we;
                m_iter = int'(b_iter); m_chg = int'(b_chg); m_pa = int'(b_pa);
                m_la = int'(b_la); m_lw = int'(b_lw);
                m_cx = int'(b_cx); m_cy = int'(b_cy); m_cz = int'(b_cz);
            end
            2: begin
                m_busy = c_busy; m_done = c_done; m_we = c_we;
                m_iter = int'(c_iter); m_chg = int'(c_chg); m_pa = int'(c_pa);
                m_la = int'(c_la); m_lw = int'(c_lw);
                m_cx = int'(c_cx); m_cy = int'(c_cy); m_cz = int'(c_cz);
            end
            default: begin
                m_busy = a_busy; m_done = a_done; m_we = a_we;
                m_iter = int'(a_iter); m_chg = int'(a_chg); m_pa = int'(a_pa);
                m_la = int'(a_la); m_lw = int'(a_lw);
                m_cx = int'(a_cx); m_cy = int'(a_cy); m_cz = int'(a_cz);
            end
        endcase
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Reference k-means: expected labels per pass, changed counts, pass count and final centroids.
    int e_lbl [16][64];
    int e_chg [16];
    int e_pass;
    int e_cx [16];
    int e_cy [16];
    int e_cz [16];

    task automatic model(input int n, input int k, input int maxit);
        int cx[16], cy[16], cz[16], sx[16], sy[16], sz[16], cnt[16], prev[64];
        int chg, best, bd, d, dx, dy, dz;
        for (int j = 0; j < k; j++) begin
            cx[j] = int'(mx[j]); cy[j] = int'(my[j]); cz[j] = int'(mz[j]);
        end
        for (int p = 0; p < n; p++) prev[p] = -1;
        e_pass = 0;
        do begin
            chg = 0;
            for (int j = 0; j < k; j++) begin
                sx[j] = 0; sy[j] = 0; sz[j] = 0; cnt[j] = 0;
            end
            for (int p = 0; p < n; p++) begin
                best = 0; bd = -1;
                for (int j = 0; j < k; j++) begin
                    dx = int'(mx[p]) - cx[j];
                    dy = int'(my[p]) - cy[j];
                    dz = int'(mz[p]) - cz[j];
                    d  = dx*dx + dy*dy + dz*dz;
                    if (bd < 0 || d < bd) begin
                        bd = d; best = j;
                    end
                end
                e_lbl[e_pass][p] = best;
                if (prev[p] != best) chg++;
                prev[p] = best;
                sx[best] += int'(mx[p]); sy[best] += int'(my[p]); sz[best] += int'(mz[p]);
                cnt[best]++;
            end
            for (int j = 0; j < k; j++) begin
                if (cnt[j] > 0) begin
                    cx[j] = sx[j] / cnt[j]; cy[j] = sy[j] / cnt[j]; cz[j] = sz[j] / cnt[j];
                end
            end
            e_chg[e_pass] = chg;
            e_pass++;
        end while (chg != 0 && e_pass < maxit);
        for (int j = 0; j < k; j++) begin
            e_cx[j] = cx[j]; e_cy[j] = cy[j]; e_cz[j] = cz[j];
        end
    endtask

    // Label-write checker: every strobe must match the model's next (pass, point).
    bit active = 1'b0;
    int cur_n, cur_pass, wr_idx;
    always @(negedge clk) begin
        if (active) begin
            chk("busy_done_exclusive", int'(m_busy && m_done), 0);
            if (m_we) begin
                if (cur_pass >= e_pass) begin
                    chk("extra_label_write_pass", cur_pass, e_pass - 1);
                end else begin
                    chk("lbl_addr", m_la, wr_idx);
                    chk("lbl_wdata", m_lw, e_lbl[cur_pass][wr_idx]);
                end
                wr_idx++;
                if (wr_idx == cur_n) begin
                    wr_idx = 0;
                    cur_pass++;
                end
            end
        end
    end

    task automatic setp(input int p, input int x, input int y, input int z);
        mx[p] = 8'(x); my[p] = 8'(y); mz[p] = 8'(z);
    endtask

    task automatic pulse_start(input int s);
        @(negedge clk);
        case (s)
            1:       st_b = 1'b1;
            2:       st_c = 1'b1;
            default: st_a = 1'b1;
        endcase
        @(negedge clk);
        st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
    endtask

    task automatic run_scn(input string nm, input int s, input int n, input int k, input int maxit);
        int cyc;
        sel = s;
        model(n, k, maxit);
        cur_n = n; cur_pass = 0; wr_idx = 0;
        active = 1'b1;
        pulse_start(s);
        chk({nm, "_busy_after_start"}, int'(m_busy), 1);
        chk({nm, "_done_cleared"}, int'(m_done), 0);
        cyc = 0;
        while (!m_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_done_reached"}, int'(m_done), 1);
        active = 1'b0;
        chk({nm, "_busy_at_done"}, int'(m_busy), 0);
        chk({nm, "_iter_count"}, m_iter, e_pass);
        chk({nm, "_changed_count"}, m_chg, e_chg[e_pass-1]);
        chk({nm, "_passes_written"}, cur_pass, e_pass);
        chk({nm, "_partial_pass"}, wr_idx, 0);
        for (int j = 0; j < k; j++) begin
            csel = j;
            #1;
            chk({nm, "_cen_x"}, m_cx, e_cx[j]);
            chk({nm, "_cen_y"}, m_cy, e_cy[j]);
            chk({nm, "_cen_z"}, m_cz, e_cz[j]);
        end
        csel = 0;
    endtask

    task automatic load_basic();
        setp(0, 0, 0, 0); setp(1, 10, 0, 0); setp(2, 2, 0, 0); setp(3, 12, 0, 0);
    endtask

    initial begin
        rst = 1'b1; st_a = 1'b0; st_b = 1'b0; st_c = 1'b0; csel = 0; sel = 0;
        for (int p = 0; p < 64; p++) setp(p, 0, 0, 0);
        #12;
        chk("rst_busy", int'(m_busy), 0);
        chk("rst_done", int'(m_done), 0);
        chk("rst_iter", m_iter, 0);
        chk("rst_changed", m_chg, 0);
        chk("rst_lbl_we", int'(m_we), 0);
        chk("rst_pt_addr", m_pa, 0);
        chk("rst_lbl_addr", m_la, 0);
        chk("rst_lbl_wdata", m_lw, 0);
        @(negedge clk);
        rst = 1'b0;

        load_basic();
        run_scn("basic", 0, 4, 2, 16);
        chk("basic_model_lbl1", e_lbl[0][1], 1);
        chk("basic_model_lbl2", e_lbl[0][2], 0);
        chk("basic_model_lbl3", e_lbl[0][3], 1);
        chk("basic_model_chg1", e_chg[0], 4);
        chk("basic_model_cen0x", e_cx[0], 1);
        chk("basic_model_cen1x", e_cx[1], 11);
        chk("basic_iter_literal", m_iter, 2);
        chk("basic_changed_literal", m_chg, 0);

        run_scn("cap", 1, 4, 2, 1);
        chk("cap_iter_literal", m_iter, 1);
        chk("cap_changed_literal", m_chg, 4);

        setp(0, 0, 0, 0); setp(1, 4, 0, 0); setp(2, 2, 0, 0); setp(3, 2, 0, 0);
        run_scn("tie", 0, 4, 2, 16);
        chk("tie_model_lbl2", e_lbl[0][2], 0);
        chk("tie_model_lbl3", e_lbl[0][3], 0);

        for (int p = 0; p < 4; p++) setp(p, 5, 5, 5);
        run_scn("empty", 0, 4, 2, 16);
        chk("empty_iter_literal", m_iter, 2);
        csel = 1;
        #1;
        chk("empty_cen1_x_literal", m_cx, 5);
        chk("empty_cen1_z_literal", m_cz, 5);
        csel = 0;

        // Abort a run in the first DIST cycle of pass 1, then rerun.
        load_basic();
        sel = 0;
        pulse_start(0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_busy_before_rst", int'(m_busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(m_busy), 0);
        chk("abort_done", int'(m_done), 0);
        chk("abort_iter", m_iter, 0);
        chk("abort_changed", m_chg, 0);
        chk("abort_lbl_we", int'(m_we), 0);
        chk("abort_pt_addr", m_pa, 0);
        chk("abort_lbl_addr", m_la, 0);
        chk("abort_lbl_wdata", m_lw, 0);
        csel = 1;
        #1;
        chk("abort_cen1_x", m_cx, 0);
        csel = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_scn("rerun", 0, 4, 2, 16);
        chk("rerun_iter_literal", m_iter, 2);

        for (int p = 0; p < 41; p++)
            setp(p, (p % 7) * 36 + (p * 13) % 9, (p % 5) * 50 + (p * 7) % 11, (p * 29) % 256);
        run_scn("dflt", 2, 41, 7, 16);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
